tinuc_alu: RTL and testbench
============================

# tinuc_alu

32-bit integer ALU for the TINUC RV32I-style datapath. It performs add, subtract, shifts, signed and unsigned compares, and bitwise logic, selected by a 5-bit control code. It produces a result plus zero, negative, carry and overflow flags. It sits in the execute stage between the operand muxes and the writeback/branch logic.

## Interface
Parameters:
- none (data width fixed at 32).

Ports:
- clk  input  1  clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- src_a  input  32  operand A.
- src_b  input  32  operand B; bits [4:0] are the shift amount for shift operations.
- alu_control  input  5  operation select (encodings below).
- alu_result  output  32  operation result.
- zero  output  1  high when alu_result == 0.
- negative  output  1  alu_result[31].
- carry  output  1  carry-out of ADD; NOT borrow of SUB (1 = no borrow); 0 for all other ops.
- overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops.

## Operation
Encodings:
- 00000 ADD: a + b, mod 2^32.
- 00001 SUB: a − b, mod 2^32.
- 00010 SLL: a << b[4:0].
- 00011 SLT: 1 if a < b as signed, else 0; zero-extended to 32 bits.
- 00100 SLTU: 1 if a < b as unsigned, else 0; zero-extended to 32 bits.
- 00101 XOR: a ^ b.
- 00110 SRL: a >> b[4:0], zero fill.
- 00111 SRA: a >>> b[4:0], sign fill from a[31].
- 01000 OR: a | b.
- 01001 AND: a & b.
- 01010–11111: reserved; result 32'h0, so zero = 1 and carry/overflow = 0.

Arithmetic and width rules:
- b[31:5] is ignored for shifts.
- A shift by 0 returns a unchanged.
- A shift by 31 is legal.
- One shared 33-bit adder computes a + (b ^ {32{sub}}) + sub.
  - carry = bit 32 of this sum.
  - overflow = (a[31] == b'[31]) && (sum[31] != a[31]), where b' is the post-inversion B.
- SLT uses sum[31] ^ overflow of the subtraction.
- SLTU uses the NOT of the subtraction carry.
- All four flags are derived from the selected result or op in the same path as alu_result.

## Timing
- Default build is fully combinational: outputs settle within the same cycle as input changes. clk and rst are unused in this build but stay on the port list.
- With ALU_REG_OUT_EN defined, the behaviour is as in Configuration.
- Reset has no effect on the combinational path.

## Configuration
- Macro: ALU_REG_OUT_EN.
- Undefined (default): combinational outputs, zero latency.
- Defined: alu_result, zero, negative, carry and overflow are registered on rising clk.
  - Latency is 1 cycle: inputs sampled at edge N appear after edge N.
  - When rst = 1 at an edge, all outputs become 0, including zero = 0. Inputs sampled in that cycle are discarded.
  - The first result after reset deassertion appears one edge after rst falls.
  - Back-to-back operations are allowed every cycle; there is no handshake or stall.

## Test plan
- ADD a=10, b=20 -> result 30, zero=0, carry=0, overflow=0. ADD a=32'h7FFFFFFF, b=1 -> 32'h80000000, overflow=1, negative=1.
- SUB a=15, b=15 -> result 0, zero=1, carry=1. SUB a=0, b=1 -> 32'hFFFFFFFF, carry=0.
- AND and OR with a=32'h0000FFFF, b=32'hFFFF0000 -> AND gives 32'h00000000 with zero=1; OR gives 32'hFFFFFFFF.
- SLT a=−10, b=5 -> 1. SLTU with the same operands -> 0. SLT a=32'h80000000, b=32'h7FFFFFFF -> 1.
- SRA a=−8, b=1 -> 32'hFFFFFFFC. SRL same operands -> 32'h7FFFFFFC. SLL a=1, b=32'h00000023 -> 32'h00000008 (amount 3). Reserved code 01111 -> 0 with zero=1.
- With ALU_REG_OUT_EN:
  - Assert rst for one edge -> all outputs 0.
  - Then apply ADD 10+20 -> result 30 visible only after the next edge.
  - Assert rst mid-stream -> outputs 0 on that edge.

Source files
------------

// File: rtl/tinuc_alu_if.sv
// ============================================================================
//  Module      : tinuc_alu_if
//  Description : Operand/result bundle between the TINUC execute-stage
//                operand muxes and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tinuc_alu_if;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [4:0]  alu_control;
   logic [31:0] alu_result;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   // The datapath drives operands and consumes results
   modport master (
      output src_a, src_b, alu_control,
      input  alu_result, zero, negative, carry, overflow
   );

   // The ALU consumes operands and drives results
   modport slave (
      input  src_a, src_b, alu_control,
      output alu_result, zero, negative, carry, overflow
   );
endinterface

`default_nettype wire

// File: rtl/tinuc_alu.sv
// ============================================================================
//  Module      : tinuc_alu
//  Description : 32-bit RV32I-style integer ALU (add/sub, shifts, signed and
//                unsigned compare, bitwise logic) with zero/negative/carry/
//                overflow flags. Combinational by default; define
//                ALU_REG_OUT_EN to register all outputs (1-cycle latency,
//                synchronous active-high reset clears them).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tinuc_alu (
   input  wire logic     clk,
   input  wire logic     rst,
   tinuc_alu_if.slave    bus
);

   localparam logic [4:0] c_op_add  = 5'b00000;
   localparam logic [4:0] c_op_sub  = 5'b00001;
   localparam logic [4:0] c_op_sll  = 5'b00010;
   localparam logic [4:0] c_op_slt  = 5'b00011;
   localparam logic [4:0] c_op_sltu = 5'b00100;
   localparam logic [4:0] c_op_xor  = 5'b00101;
   localparam logic [4:0] c_op_srl  = 5'b00110;
   localparam logic [4:0] c_op_sra  = 5'b00111;
   localparam logic [4:0] c_op_or   = 5'b01000;
   localparam logic [4:0] c_op_and  = 5'b01001;

   logic        w_sub;
   logic [31:0] w_b_mod;
   logic [32:0] w_sum;
   logic        w_add_ovf;
   logic [4:0]  w_shamt;
   logic [31:0] w_result;
   logic        w_zero;
   logic        w_negative;
   logic        w_carry;
   logic        w_overflow;

   // SLT/SLTU reuse the subtractor, so they also invert B
   assign w_sub = (bus.alu_control == c_op_sub) ||
                  (bus.alu_control == c_op_slt) ||
                  (bus.alu_control == c_op_sltu);

   // Single shared 33-bit adder: a + (b ^ {32{sub}}) + sub
   assign w_b_mod   = bus.src_b ^ {32{w_sub}};
   assign w_sum     = {1'b0, bus.src_a} + {1'b0, w_b_mod} + {32'd0, w_sub};
   assign w_add_ovf = (bus.src_a[31] == w_b_mod[31]) && (w_sum[31] != bus.src_a[31]);
   assign w_shamt   = bus.src_b[4:0];

   // Result select and op-dependent carry/overflow; reserved codes yield zero
   always_comb begin
      w_result   = 32'd0;
      w_carry    = 1'b0;
      w_overflow = 1'b0;
      case (bus.alu_control)
         c_op_add, c_op_sub: begin
            w_result   = w_sum[31:0];
            w_carry    = w_sum[32];
            w_overflow = w_add_ovf;
         end
         c_op_sll:  w_result = bus.src_a << w_shamt;
         c_op_slt:  w_result = {31'd0, w_sum[31] ^ w_add_ovf};
         c_op_sltu: w_result = {31'd0, ~w_sum[32]};
         c_op_xor:  w_result = bus.src_a ^ bus.src_b;
         c_op_srl:  w_result = bus.src_a >> w_shamt;
         c_op_sra:  w_result = $signed(bus.src_a) >>> w_shamt;
         c_op_or:   w_result = bus.src_a | bus.src_b;
         c_op_and:  w_result = bus.src_a & bus.src_b;
         default:   w_result = 32'd0;
      endcase
   end

   assign w_zero     = (w_result == 32'd0);
   assign w_negative = w_result[31];

`ifdef ALU_REG_OUT_EN
   logic [31:0] r_result;
   logic        r_zero;
   logic        r_negative;
   logic        r_carry;
   logic        r_overflow;

   // Output stage: reset forces every output low, including zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result   <= 32'd0;
         r_zero     <= 1'b0;
         r_negative <= 1'b0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_result   <= w_result;
         r_zero     <= w_zero;
         r_negative <= w_negative;
         r_carry    <= w_carry;
         r_overflow <= w_overflow;
      end
   end

   assign bus.alu_result = r_result;
   assign bus.zero       = r_zero;
   assign bus.negative   = r_negative;
   assign bus.carry      = r_carry;
   assign bus.overflow   = r_overflow;
`else
   // Clock and reset remain on the port list but do not touch this path
   logic w_unused_clk_rst;
   assign w_unused_clk_rst = clk ^ rst;

   assign bus.alu_result = w_result;
   assign bus.zero       = w_zero;
   assign bus.negative   = w_negative;
   assign bus.carry      = w_carry;
   assign bus.overflow   = w_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tinuc_alu.sv
// ============================================================================
//  Module      : tb_tinuc_alu
//  Description : Directed self-checking bench for tinuc_alu. Works for both
//                the combinational build and the ALU_REG_OUT_EN build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tinuc_alu;

   localparam logic [4:0] c_add  = 5'b00000;
   localparam logic [4:0] c_sub  = 5'b00001;
   localparam logic [4:0] c_sll  = 5'b00010;
   localparam logic [4:0] c_slt  = 5'b00011;
   localparam logic [4:0] c_sltu = 5'b00100;
   localparam logic [4:0] c_xor  = 5'b00101;
   localparam logic [4:0] c_srl  = 5'b00110;
   localparam logic [4:0] c_sra  = 5'b00111;
   localparam logic [4:0] c_or   = 5'b01000;
   localparam logic [4:0] c_and  = 5'b01001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   tinuc_alu_if bus ();

   tinuc_alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Observed outputs packed as {result, zero, negative, carry, overflow}
   function automatic logic [35:0] observed();
      return {bus.alu_result, bus.zero, bus.negative, bus.carry, bus.overflow};
   endfunction

   // Drive one operation and wait until its outputs are valid
   task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.alu_control = op;
      bus.src_a       = a;
      bus.src_b       = b;
`ifdef ALU_REG_OUT_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic test_reset();
      logic [35:0] got;
`ifdef ALU_REG_OUT_EN
      rst = 1'b1;
      apply(c_add, 32'd10, 32'd20);
      got = observed();
      total++;
      if (got !== 36'h0) begin
         bad++;
         $display("FAIL reset_outputs: got %h want %h", got, 36'h0);
      end
      rst = 1'b0;
      bus.alu_control = c_add; bus.src_a = 32'd10; bus.src_b = 32'd20;
      #1;
      got = observed();
      total++;
      if (got !== 36'h0) begin
         bad++;
         $display("FAIL reset_no_early_result: got %h want %h", got, 36'h0);
      end
      @(posedge clk);
      #1;
      got = observed();
      total++;
      if (got !== {32'd30, 4'b0000}) begin
         bad++;
         $display("FAIL reset_first_result: got %h want %h", got, {32'd30, 4'b0000});
      end
`else
      rst = 1'b1;
      apply(c_add, 32'd10, 32'd20);
      got = observed();
      total++;
      if (got !== {32'd30, 4'b0000}) begin
         bad++;
         $display("FAIL reset_comb_unaffected: got %h want %h", got, {32'd30, 4'b0000});
      end
      rst = 1'b0;
`endif
   endtask

   task automatic test_add_sub();
      logic [35:0] got;
      apply(c_add, 32'd10, 32'd20);
      got = observed(); total++;
      if (got !== {32'd30, 4'b0000}) begin bad++; $display("FAIL add_10_20: got %h want %h", got, {32'd30, 4'b0000}); end
      apply(c_add, 32'h7FFFFFFF, 32'd1);
      got = observed(); total++;
      if (got !== {32'h80000000, 4'b0101}) begin bad++; $display("FAIL add_ovf: got %h want %h", got, {32'h80000000, 4'b0101}); end
      apply(c_add, 32'hFFFFFFFF, 32'd1);
      got = observed(); total++;
      if (got !== {32'h0, 4'b1010}) begin bad++; $display("FAIL add_carry: got %h want %h", got, {32'h0, 4'b1010}); end
      apply(c_sub, 32'd15, 32'd15);
      got = observed(); total++;
      if (got !== {32'h0, 4'b1010}) begin bad++; $display("FAIL sub_equal: got %h want %h", got, {32'h0, 4'b1010}); end
      apply(c_sub, 32'd0, 32'd1);
      got = observed(); total++;
      if (got !== {32'hFFFFFFFF, 4'b0100}) begin bad++; $display("FAIL sub_borrow: got %h want %h", got, {32'hFFFFFFFF, 4'b0100}); end
      apply(c_sub, 32'h80000000, 32'd1);
      got = observed(); total++;
      if (got !== {32'h7FFFFFFF, 4'b0011}) begin bad++; $display("FAIL sub_ovf: got %h want %h", got, {32'h7FFFFFFF, 4'b0011}); end
   endtask

   task automatic test_logic();
      logic [35:0] got;
      apply(c_and, 32'h0000FFFF, 32'hFFFF0000);
      got = observed(); total++;
      if (got !== {32'h0, 4'b1000}) begin bad++; $display("FAIL and: got %h want %h", got, {32'h0, 4'b1000}); end
      apply(c_or, 32'h0000FFFF, 32'hFFFF0000);
      got = observed(); total++;
      if (got !== {32'hFFFFFFFF, 4'b0100}) begin bad++; $display("FAIL or: got %h want %h", got, {32'hFFFFFFFF, 4'b0100}); end
      apply(c_xor, 32'h0F0F0F0F, 32'hFF00FF00);
      got = observed(); total++;
      if (got !== {32'hF00FF00F, 4'b0100}) begin bad++; $display("FAIL xor: got %h want %h", got, {32'hF00FF00F, 4'b0100}); end
   endtask

   task automatic test_compare();
      logic [35:0] got;
      apply(c_slt, 32'hFFFFFFF6, 32'd5);
      got = observed(); total++;
      if (got !== {32'd1, 4'b0000}) begin bad++; $display("FAIL slt_neg_pos: got %h want %h", got, {32'd1, 4'b0000}); end
      apply(c_sltu, 32'hFFFFFFF6, 32'd5);
      got = observed(); total++;
      if (got !== {32'd0, 4'b1000}) begin bad++; $display("FAIL sltu_big_small: got %h want %h", got, {32'd0, 4'b1000}); end
      apply(c_slt, 32'h80000000, 32'h7FFFFFFF);
      got = observed(); total++;
      if (got !== {32'd1, 4'b0000}) begin bad++; $display("FAIL slt_ovf_case: got %h want %h", got, {32'd1, 4'b0000}); end
      apply(c_slt, 32'd5, 32'hFFFFFFF6);
      got = observed(); total++;
      if (got !== {32'd0, 4'b1000}) begin bad++; $display("FAIL slt_pos_neg: got %h want %h", got, {32'd0, 4'b1000}); end
      apply(c_sltu, 32'd5, 32'hFFFFFFF6);
      got = observed(); total++;
      if (got !== {32'd1, 4'b0000}) begin bad++; $display("FAIL sltu_small_big: got %h want %h", got, {32'd1, 4'b0000}); end
   endtask

   task automatic test_shift();
      logic [35:0] got;
      apply(c_sra, 32'hFFFFFFF8, 32'd1);
      got = observed(); total++;
      if (got !== {32'hFFFFFFFC, 4'b0100}) begin bad++; $display("FAIL sra_1: got %h want %h", got, {32'hFFFFFFFC, 4'b0100}); end
      apply(c_srl, 32'hFFFFFFF8, 32'd1);
      got = observed(); total++;
      if (got !== {32'h7FFFFFFC, 4'b0000}) begin bad++; $display("FAIL srl_1: got %h want %h", got, {32'h7FFFFFFC, 4'b0000}); end
      apply(c_sll, 32'd1, 32'h00000023);
      got = observed(); total++;
      if (got !== {32'h8, 4'b0000}) begin bad++; $display("FAIL sll_masked: got %h want %h", got, {32'h8, 4'b0000}); end
      apply(c_sll, 32'h12345678, 32'hFFFFFFE0);
      got = observed(); total++;
      if (got !== {32'h12345678, 4'b0000}) begin bad++; $display("FAIL sll_0: got %h want %h", got, {32'h12345678, 4'b0000}); end
      apply(c_sra, 32'h80000000, 32'd31);
      got = observed(); total++;
      if (got !== {32'hFFFFFFFF, 4'b0100}) begin bad++; $display("FAIL sra_31: got %h want %h", got, {32'hFFFFFFFF, 4'b0100}); end
      apply(c_srl, 32'h80000000, 32'd31);
      got = observed(); total++;
      if (got !== {32'h1, 4'b0000}) begin bad++; $display("FAIL srl_31: got %h want %h", got, {32'h1, 4'b0000}); end
      apply(c_sll, 32'd1, 32'd31);
      got = observed(); total++;
      if (got !== {32'h80000000, 4'b0100}) begin bad++; $display("FAIL sll_31: got %h want %h", got, {32'h80000000, 4'b0100}); end
   endtask

   task automatic test_reserved();
      logic [35:0] got;
      apply(5'b01111, 32'd5, 32'd7);
      got = observed(); total++;
      if (got !== {32'h0, 4'b1000}) begin bad++; $display("FAIL rsv_01111: got %h want %h", got, {32'h0, 4'b1000}); end
      apply(5'b01010, 32'hFFFFFFFF, 32'd1);
      got = observed(); total++;
      if (got !== {32'h0, 4'b1000}) begin bad++; $display("FAIL rsv_01010: got %h want %h", got, {32'h0, 4'b1000}); end
      apply(5'b11111, 32'h7FFFFFFF, 32'd1);
      got = observed(); total++;
      if (got !== {32'h0, 4'b1000}) begin bad++; $display("FAIL rsv_11111: got %h want %h", got, {32'h0, 4'b1000}); end
   endtask

   task automatic test_back_to_back();
      logic [35:0] got;
      apply(c_add, 32'd1, 32'd2);
      got = observed(); total++;
      if (got !== {32'd3, 4'b0000}) begin bad++; $display("FAIL b2b_add: got %h want %h", got, {32'd3, 4'b0000}); end
`ifdef ALU_REG_OUT_EN
      rst = 1'b1;
      apply(c_sub, 32'd0, 32'd1);
      got = observed(); total++;
      if (got !== 36'h0) begin bad++; $display("FAIL b2b_mid_reset: got %h want %h", got, 36'h0); end
      rst = 1'b0;
`endif
      apply(c_xor, 32'hAAAA5555, 32'hFFFFFFFF);
      got = observed(); total++;
      if (got !== {32'h5555AAAA, 4'b0000}) begin bad++; $display("FAIL b2b_xor: got %h want %h", got, {32'h5555AAAA, 4'b0000}); end
      apply(c_sub, 32'd5, 32'd3);
      got = observed(); total++;
      if (got !== {32'd2, 4'b0010}) begin bad++; $display("FAIL b2b_sub: got %h want %h", got, {32'd2, 4'b0010}); end
   endtask

   // Test sequence
   initial begin
      bus.alu_control = 5'd0;
      bus.src_a       = 32'd0;
      bus.src_b       = 32'd0;
      @(negedge clk);
      test_reset();
      test_add_sub();
      test_logic();
      test_compare();
      test_shift();
      test_reserved();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
